// File: rtl/tl_rx_vc_pkg.sv
// Shared state encoding and sizing helpers for the RX VC payload buffer write path.
// The DRAIN state only exists when TL_RX_VC_OVERFLOW_CHECK_EN is defined.
package tl_rx_vc_pkg;

  localparam int unsigned DATA_FIELD_SIZE_DFLT = 12;
  localparam int unsigned ADDRESS_SIZE         = DATA_FIELD_SIZE_DFLT - 2;
  localparam int unsigned DEPTH                = 1 << ADDRESS_SIZE;

  // Pointers carry one wrap bit above the entry address.
  function automatic int unsigned ptr_width(input int unsigned data_field_size);
    return data_field_size - 1;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_COMMIT  = 3'd2,
`ifdef TL_RX_VC_OVERFLOW_CHECK_EN
    ST_DISCARD = 3'd3,
    ST_DRAIN   = 3'd4
`else
    ST_DISCARD = 3'd3
`endif
  } wr_state_e;

endpackage

// File: rtl/tl_rx_vc_space_calc.sv
// Buffer occupancy from the shadow write counter and the read pointer.
module tl_rx_vc_space_calc #(
  parameter int unsigned PTR_W = 11
) (
  input  logic [PTR_W-1:0] wr_cnt,
  input  logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W-1:0] occupancy,
  output logic             full
);

  localparam int unsigned DEPTH_L = 1 << (PTR_W - 1);

  assign occupancy = wr_cnt - rd_ptr;
  assign full      = (occupancy == PTR_W'(DEPTH_L));

endmodule

// File: rtl/tl_rx_vc_data_write_ctrl.sv
// Write-side controller for the RX VC payload buffer: writes beats, commits clean TLPs, rewinds bad ones.
// Overflow detection and the DRAIN state are built only with TL_RX_VC_OVERFLOW_CHECK_EN defined.
module tl_rx_vc_data_write_ctrl
  import tl_rx_vc_pkg::*;
#(
  parameter int unsigned DW              = 32,
  parameter int unsigned DATA_FIELD_SIZE = 12,
  parameter int unsigned BUFFER_WIDTH    = 8 * DW
) (
  input  logic                       i_clk,
  input  logic                       i_n_rst,
  input  logic                       i_dll_valid,
  input  logic                       i_dll_sop,
  input  logic                       i_dll_eop,
  input  logic                       i_dll_abort,
  input  logic                       i_dll_half,
  input  logic [BUFFER_WIDTH-1:0]    i_dll_data,
  input  logic [DATA_FIELD_SIZE-2:0] i_r_data_ptr,
  output logic [BUFFER_WIDTH-1:0]    o_w_tlp_data,
  output logic                       o_w_data_en,
  output logic                       o_w_data_ptr_ld,
  output logic                       o_w_data_cntr_ld,
  output logic                       o_hdr_write_flag,
  output logic                       o_tlp_commit,
  output logic [DATA_FIELD_SIZE-2:0] o_tlp_beats,
  output logic                       o_overflow_err,
  output logic                       o_drop_err
);

  localparam int unsigned PTR_W = ptr_width(DATA_FIELD_SIZE);

  wr_state_e        state, state_nxt;
  logic [PTR_W-1:0] wr_cnt, commit_ptr, beat_cnt, beat_cnt_nxt;
  logic [PTR_W-1:0] occupancy;
  logic             full_raw;
  logic             wr_en_c, ptr_ld_c, cntr_ld_c, ovf_c, drop_c;

  tl_rx_vc_space_calc #(.PTR_W(PTR_W)) u_space_calc (
    .wr_cnt    (wr_cnt),
    .rd_ptr    (i_r_data_ptr),
    .occupancy (occupancy),
    .full      (full_raw)
  );

`ifdef TL_RX_VC_OVERFLOW_CHECK_EN
  logic unused_space;
  assign unused_space = ^occupancy;
`else
  logic unused_space;
  assign unused_space = ^{occupancy, full_raw};
`endif

  // Next state and beat-level controls
  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    wr_en_c      = 1'b0;
    ptr_ld_c     = 1'b0;
    cntr_ld_c    = 1'b0;
    ovf_c        = 1'b0;
    drop_c       = 1'b0;
    case (state)
      ST_IDLE, ST_COMMIT: begin
        // COMMIT behaves like IDLE for the incoming beat so good TLPs stream back-to-back
        ptr_ld_c  = (state == ST_COMMIT);
        state_nxt = ST_IDLE;
        if (i_dll_valid) begin
          if (!i_dll_sop) begin
            drop_c = 1'b1;
          end else if (i_dll_eop && i_dll_abort) begin
            state_nxt = ST_DISCARD;
`ifdef TL_RX_VC_OVERFLOW_CHECK_EN
          end else if (full_raw) begin
            ovf_c     = 1'b1;
            state_nxt = i_dll_eop ? ST_DISCARD : ST_DRAIN;
`endif
          end else begin
            wr_en_c      = 1'b1;
            beat_cnt_nxt = PTR_W'(1);
            state_nxt    = i_dll_eop ? ST_COMMIT : ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (i_dll_valid) begin
          if (i_dll_sop) begin
            drop_c    = 1'b1;
            state_nxt = ST_DISCARD;
          end else if (i_dll_eop && i_dll_abort) begin
            state_nxt = ST_DISCARD;
`ifdef TL_RX_VC_OVERFLOW_CHECK_EN
          end else if (full_raw) begin
            ovf_c     = 1'b1;
            state_nxt = i_dll_eop ? ST_DISCARD : ST_DRAIN;
`endif
          end else begin
            wr_en_c      = 1'b1;
            beat_cnt_nxt = beat_cnt + PTR_W'(1);
            if (i_dll_eop) state_nxt = ST_COMMIT;
          end
        end
      end
      ST_DISCARD: begin
        cntr_ld_c = 1'b1;
        drop_c    = i_dll_valid;
        state_nxt = ST_IDLE;
      end
`ifdef TL_RX_VC_OVERFLOW_CHECK_EN
      ST_DRAIN: begin
        if (i_dll_valid && i_dll_eop) state_nxt = ST_DISCARD;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and shadow pointer registers; rewind takes priority over increment
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      state      <= ST_IDLE;
      wr_cnt     <= '0;
      commit_ptr <= '0;
      beat_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      if (cntr_ld_c)    wr_cnt <= commit_ptr;
      else if (wr_en_c) wr_cnt <= wr_cnt + PTR_W'(1);
      if (ptr_ld_c)     commit_ptr <= wr_cnt;
    end
  end

  assign o_w_tlp_data     = i_dll_data;
  assign o_w_data_en      = wr_en_c;
  assign o_w_data_ptr_ld  = ptr_ld_c;
  assign o_w_data_cntr_ld = cntr_ld_c;
  assign o_hdr_write_flag = wr_en_c & i_dll_sop & i_dll_half;
  assign o_tlp_commit     = ptr_ld_c;
  assign o_tlp_beats      = ptr_ld_c ? beat_cnt : '0;
  assign o_overflow_err   = ovf_c;
  assign o_drop_err       = drop_c;

endmodule

// File: tb/tb_tl_rx_vc_data_write_ctrl.sv
// Directed and randomized bench for tl_rx_vc_data_write_ctrl against a flag-based TLP reference model.
module tb_tl_rx_vc_data_write_ctrl;

  localparam int unsigned DW    = 32;
  localparam int unsigned DFS   = 12;
  localparam int unsigned BW    = 8 * DW;
  localparam int unsigned PW    = DFS - 1;
  localparam int          MASK  = (1 << PW) - 1;
  localparam int          DEPTH = 1 << (DFS - 2);
`ifdef TL_RX_VC_OVERFLOW_CHECK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          n_rst;
  logic          valid, sop, eop, abort, half;
  logic [BW-1:0] data;
  logic [PW-1:0] rd_ptr;
  logic [BW-1:0] w_tlp_data;
  logic          w_data_en, w_data_ptr_ld, w_data_cntr_ld, hdr_write_flag;
  logic          tlp_commit, overflow_err, drop_err;
  logic [PW-1:0] tlp_beats;

  int errors = 0;
  int checks = 0;

  // Reference model: pointers as plain integers plus TLP-progress flags
  int m_wr, m_cp, m_len;
  bit m_open, m_drain, m_commit_due, m_rewind_due;

  always #5 clk = ~clk;

  tl_rx_vc_data_write_ctrl #(.DW(DW), .DATA_FIELD_SIZE(DFS), .BUFFER_WIDTH(BW)) dut (
    .i_clk            (clk),
    .i_n_rst          (n_rst),
    .i_dll_valid      (valid),
    .i_dll_sop        (sop),
    .i_dll_eop        (eop),
    .i_dll_abort      (abort),
    .i_dll_half       (half),
    .i_dll_data       (data),
    .i_r_data_ptr     (rd_ptr),
    .o_w_tlp_data     (w_tlp_data),
    .o_w_data_en      (w_data_en),
    .o_w_data_ptr_ld  (w_data_ptr_ld),
    .o_w_data_cntr_ld (w_data_cntr_ld),
    .o_hdr_write_flag (hdr_write_flag),
    .o_tlp_commit     (tlp_commit),
    .o_tlp_beats      (tlp_beats),
    .o_overflow_err   (overflow_err),
    .o_drop_err       (drop_err)
  );

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_wr = 0; m_cp = 0; m_len = 0;
    m_open = 0; m_drain = 0; m_commit_due = 0; m_rewind_due = 0;
  endtask

  task automatic do_reset();
    n_rst = 1'b0; valid = 0; sop = 0; eop = 0; abort = 0; half = 0;
    data = {8{32'h5a5a_0f0f}}; rd_ptr = '0;
    #2;
    model_clear();
    chk("rst_en", BW'(w_data_en), '0);
    chk("rst_ptr_ld", BW'(w_data_ptr_ld), '0);
    chk("rst_cntr_ld", BW'(w_data_cntr_ld), '0);
    chk("rst_hdr", BW'(hdr_write_flag), '0);
    chk("rst_commit", BW'(tlp_commit), '0);
    chk("rst_beats", BW'(tlp_beats), '0);
    chk("rst_ovf", BW'(overflow_err), '0);
    chk("rst_drop", BW'(drop_err), '0);
    chk("rst_data", w_tlp_data, data);
    chk("rst_wr_cnt", BW'(dut.wr_cnt), '0);
    chk("rst_commit_ptr", BW'(dut.commit_ptr), '0);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  // One clock: drive a beat, predict, compare mid-cycle, then advance the model
  task automatic step(input bit v, input bit s, input bit e, input bit a, input bit h,
                      input bit follow, input int rd);
    bit e_en, e_pld, e_cld, e_com, e_ovf, e_drop, e_hdr, full;
    int e_beats, rdp, n_wr, n_cp;
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) data[k*32 +: 32] = $urandom();
    rdp = follow ? m_wr : (rd & MASK);
    valid = v; sop = s; eop = e; abort = a; half = h; rd_ptr = PW'(rdp);
    full = OVF_EN && (((m_wr - rdp) & MASK) == DEPTH);
    {e_en, e_pld, e_cld, e_com, e_ovf, e_drop, e_hdr} = '0;
    e_beats = 0;
    if (m_rewind_due) begin
      e_cld = 1; e_drop = v; m_rewind_due = 0;
    end else begin
      if (m_commit_due) begin
        e_pld = 1; e_com = 1; e_beats = m_len; m_commit_due = 0;
      end
      if (v) begin
        if (m_drain) begin
          if (e) begin m_drain = 0; m_rewind_due = 1; end
        end else if (!m_open) begin
          if (!s) e_drop = 1;
          else if (e && a) m_rewind_due = 1;
          else if (full) begin
            e_ovf = 1;
            if (e) m_rewind_due = 1; else m_drain = 1;
          end else begin
            e_en = 1; e_hdr = h; m_len = 1;
            if (e) m_commit_due = 1; else m_open = 1;
          end
        end else begin
          if (s) begin e_drop = 1; m_open = 0; m_rewind_due = 1; end
          else if (e && a) begin m_open = 0; m_rewind_due = 1; end
          else if (full) begin
            e_ovf = 1; m_open = 0;
            if (e) m_rewind_due = 1; else m_drain = 1;
          end else begin
            e_en = 1; m_len++;
            if (e) begin m_open = 0; m_commit_due = 1; end
          end
        end
      end
    end
    #3;
    chk("w_data_en", BW'(w_data_en), BW'(e_en));
    chk("w_tlp_data", w_tlp_data, data);
    chk("hdr_write_flag", BW'(hdr_write_flag), BW'(e_hdr));
    chk("w_data_ptr_ld", BW'(w_data_ptr_ld), BW'(e_pld));
    chk("w_data_cntr_ld", BW'(w_data_cntr_ld), BW'(e_cld));
    chk("tlp_commit", BW'(tlp_commit), BW'(e_com));
    chk("tlp_beats", BW'(tlp_beats), BW'(e_beats & MASK));
    chk("overflow_err", BW'(overflow_err), BW'(e_ovf));
    chk("drop_err", BW'(drop_err), BW'(e_drop));
    chk("wr_cnt", BW'(dut.wr_cnt), BW'(m_wr));
    chk("commit_ptr", BW'(dut.commit_ptr), BW'(m_cp));
    n_cp = e_pld ? m_wr : m_cp;
    n_wr = e_cld ? m_cp : ((m_wr + (e_en ? 1 : 0)) & MASK);
    m_cp = n_cp; m_wr = n_wr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1, 0);
  endtask

  // Multi-beat good TLP with the read side either tracking or held at rd
  task automatic tlp(input int beats, input bit follow, input int rd);
    for (int i = 0; i < beats; i++)
      step(1, i == 0, i == beats - 1, 0, i == 0, follow, rd);
  endtask

  initial begin
    int r0, n;
    do_reset();

    // 3-beat TLP, read ptr 0
    tlp(3, 0, 0);
    idle(2);
    // back-to-back 1-beat TLPs
    step(1, 1, 1, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0);
    idle(2);
    // 4-beat TLP aborted on eop
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0, 0);
    idle(2);
    // valid without sop in IDLE, then sop during WRITE
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 1, 0);
    step(1, 0, 1, 0, 0, 1, 0);
    idle(2);
    // reset in the middle of a TLP, then a fresh TLP from pointer 0
    step(1, 1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    do_reset();
    tlp(1, 1, 0);
    idle(2);

    // randomized traffic, read side mostly tracking, sometimes near full
    for (int i = 0; i < 400; i++) begin
      bit fol;
      fol = ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1, fol,
           m_wr - $urandom_range(DEPTH - 4, DEPTH));
    end
    idle(3);

    // fill DEPTH entries with the read pointer held, then one more TLP
    r0 = m_wr;
    tlp(DEPTH, 0, r0);
    step(0, 0, 0, 0, 0, 0, r0);
    step(1, 1, 0, 0, 0, 0, r0);
    step(1, 0, 0, 0, 0, 0, r0);
    step(1, 0, 1, 0, 0, 0, r0);
    idle(3);

    // walk commit_ptr to the top of the pointer range, then wrap with a 2-beat TLP
    n = (MASK - m_cp) & MASK;
    if (n > 0) tlp(n, 1, 0);
    idle(2);
    tlp(2, 1, 0);
    idle(2);
    // full exactly DEPTH behind across the wrap, then one short of full
    step(1, 1, 1, 0, 0, 0, m_wr - DEPTH);
    idle(2);
    step(1, 1, 1, 0, 0, 0, m_wr - DEPTH + 1);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tl_rx_vc_data_write_ctrl.md
# tl_rx_vc_data_write_ctrl

Write-side controller for the RX virtual-channel payload buffer. It accepts payload beats (8 DW per beat) from the receive datapath and drives the buffer's write enable, commit (pointer load) and rewind (counter load) controls. A TLP becomes visible to the read side only after its last beat is written cleanly. Nullified, aborted, malformed or overflowing TLPs are rolled back. The block sits directly upstream of tl_rx_vc_data_buffer.

## Interface
Parameters:
- DW, 32, bits per double word
- DATA_FIELD_SIZE, 12, pointer width + 1; buffer DEPTH = 2^(DATA_FIELD_SIZE-2) entries; pointers are DATA_FIELD_SIZE-1 bits (one wrap bit)
- BUFFER_WIDTH, 8*DW, beat/entry width

Ports:
- i_clk  in  1  clock
- i_n_rst  in  1  reset, asynchronous, active-low
- i_dll_valid  in  1  beat valid
- i_dll_sop  in  1  first beat of TLP payload
- i_dll_eop  in  1  last beat of TLP payload
- i_dll_abort  in  1  qualifies eop: TLP nullified/ECRC bad
- i_dll_half  in  1  first beat is half-filled (4 DW header sharing entry)
- i_dll_data  in  BUFFER_WIDTH  beat data
- i_r_data_ptr  in  DATA_FIELD_SIZE-1  buffer read pointer
- o_w_tlp_data  out  BUFFER_WIDTH  = i_dll_data
- o_w_data_en  out  1  write one entry
- o_w_data_ptr_ld  out  1  commit: committed ptr <= write counter
- o_w_data_cntr_ld  out  1  rewind: write counter <= committed ptr
- o_hdr_write_flag  out  1  = i_dll_half on a written sop beat, else 0
- o_tlp_commit  out  1  one-cycle pulse per committed TLP
- o_tlp_beats  out  DATA_FIELD_SIZE-1  beat count of committed TLP, valid with o_tlp_commit
- o_overflow_err  out  1  one-cycle pulse, once per overflowing TLP
- o_drop_err  out  1  one-cycle pulse per protocol-violating beat

## Operation
- Shadow registers: wr_cnt (mirrors buffer write counter), commit_ptr, beat_cnt; all DATA_FIELD_SIZE-1 bits, modulo 2^(DATA_FIELD_SIZE-1).
- wr_cnt +1 on o_w_data_en; wr_cnt <= commit_ptr on o_w_data_cntr_ld (load wins); commit_ptr <= wr_cnt on o_w_data_ptr_ld.
- full = (wr_cnt - i_r_data_ptr) == DEPTH.
- States: IDLE, WRITE, COMMIT, DISCARD, DRAIN.
- IDLE: valid&sop writes the beat (unless full); beat_cnt <= 1. Next state: COMMIT if eop&!abort, DISCARD if eop&abort (beat not written), else WRITE. Valid without sop: o_drop_err, stay.
- WRITE: valid beat written, beat_cnt+1. eop&!abort -> COMMIT; eop&abort -> DISCARD (eop beat not written); valid&sop -> o_drop_err, DISCARD (beat dropped).
- COMMIT (1 cycle): o_w_data_ptr_ld, o_tlp_commit, o_tlp_beats=beat_cnt. A valid&sop beat in the same cycle is accepted exactly as from IDLE (back-to-back); otherwise -> IDLE.
- DISCARD (1 cycle): o_w_data_cntr_ld; o_w_data_en forced 0; any valid beat dropped with o_drop_err; -> IDLE.
- Overflow: valid beat while full in IDLE/WRITE/COMMIT -> not written, o_overflow_err, -> DRAIN (or DISCARD if that beat is eop).
- DRAIN: consume beats without writing until eop, then DISCARD.
- Reset: state IDLE, all counters 0, all outputs 0 except o_w_tlp_data (follows input).

## Timing
- Write path is combinational: o_w_data_en/o_w_tlp_data/o_hdr_write_flag in the cycle the beat is presented.
- Commit is asserted the cycle after the last written beat, so the buffer captures a counter that includes it. Beat visible to read side 1 cycle after eop.
- Rewind occurs 1 cycle after abort/violation; buffer write counter is restored before the next accepted beat.
- Reset mid-TLP: partial TLP is lost; buffer and controller both return to pointer 0.
- Max throughput: one beat per cycle, zero bubbles between good TLPs; one mandatory idle cycle after a discarded TLP.

## Configuration
- TL_RX_VC_OVERFLOW_CHECK_EN defined: full detection, DRAIN state and o_overflow_err as described.
- Undefined: full is tied 0, DRAIN is unreachable and removed, and o_overflow_err is tied 0. Flow-control credits are then the sole overflow guarantee.

## Structure
- Package tl_rx_vc_pkg: state enum, DEPTH/ADDRESS_SIZE localparams, pointer-width helper.
- One sub-module: tl_rx_vc_space_calc (wr_cnt, i_r_data_ptr -> occupancy, full).

## Test plan
- 3-beat TLP (sop, -, eop), read ptr 0 -> 3 writes; commit pulse next cycle; o_tlp_beats=3, commit_ptr=3.
- Two back-to-back 1-beat TLPs -> sop of 2nd accepted in COMMIT cycle; commit pulses on consecutive cycles; commit_ptr 1 then 2.
- 4-beat TLP with abort on eop -> 3 writes, rewind next cycle, wr_cnt back to prior commit_ptr, no o_tlp_commit.
- Fill DEPTH entries, read ptr held -> next beat: o_overflow_err once, no write, DRAIN to eop, rewind; with macro undefined the beat is written.
- Sop during WRITE and valid without sop in IDLE -> o_drop_err each; first case rewinds.
- Pointer wrap: commit_ptr at 2^(DATA_FIELD_SIZE-1)-1, 2-beat TLP -> commit_ptr=1; full computed correctly across wrap.
